gpio_host_port: RTL
===================

# gpio_host_port

Processor-side endpoint for the GPIO block: consumes the one-cycle `out_data`/`out_ready` button-capture strobes from `get_BTNinfo` and produces the `in_data`/`in_valid` write strobes consumed by `LEDindicator`. Captured switch values are buffered in a small event FIFO. A 4-register bus port lets the CPU pop events, poll status and write the LEDs. A level interrupt is raised while events are pending.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: event FIFO entries; power of two, 2..8.
- `DATA_W`, 8: width of GPIO data and the bus data path.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rstn`  in  1  reset, asynchronous and active-low.
- `gpio_data`  in  DATA_W  switch value from the GPIO `out_data`.
- `gpio_ready`  in  1  one-cycle capture strobe from the GPIO `out_ready`.
- `led_data`  out  DATA_W  LED value to the GPIO `in_data`.
- `led_valid`  out  1  one-cycle LED write strobe to the GPIO `in_valid`.
- `bus_addr`  in  2  register select.
- `bus_wen`  in  1  register write strobe.
- `bus_ren`  in  1  register read strobe.
- `bus_wdata`  in  DATA_W  write data.
- `bus_rdata`  out  DATA_W  registered read data.
- `irq`  out  1  level interrupt: FIFO not empty AND `irq_en`.

## Operation
- Register map:
  - Address 0, DATA:
    - Read returns the FIFO head and pops it.
    - Read when empty returns 0x00, with no pop and no flag change.
    - Write is ignored.
  - Address 1, STATUS: read returns {0, count[2:0], irq_en, overflow, full, not_empty}.
    - Write with bit2=1 clears `overflow` (write-1-to-clear).
    - Write bit3 loads `irq_en`.
    - All other bits are read-only.
  - Address 2, LED:
    - Write loads `led_data` and fires `led_valid`.
    - Read returns the current `led_data`.
  - Address 3: reserved; reads 0x00, writes ignored.
- Capture path:
  - Each cycle with `gpio_ready`=1 pushes `gpio_data`.
  - Push when full with no pop in the same cycle: data is dropped, sticky `overflow` is set, and contents are unchanged.
  - Push and pop in the same cycle when full: both succeed, `count` is unchanged, and `overflow` is not set.
  - Push and pop in the same cycle when empty: the pop is treated as an empty read (returns 0x00) and the push succeeds.
- Bus:
  - `bus_wen` and `bus_ren` may be asserted together.
  - Both are executed. A read of LED in the same cycle as a LED write returns the old value.
- `count` is 0..FIFO_DEPTH. Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
- `irq` is combinational from the registered `not_empty` and `irq_en`; it has no internal edge detection.

## Timing
- Reset values (asynchronous, on `rstn`=0):
  - Outputs: `led_data`=0, `led_valid`=0, `bus_rdata`=0, `irq`=0.
  - Internal state: `irq_en`=0, `overflow`=0, FIFO empty, pointers 0.
- Reset asserted mid-operation discards all FIFO contents and any pending `led_valid`.
- Read latency: `bus_rdata` is valid in the cycle after the `bus_ren` edge. It holds until the next read.
- Pop, `count` and flags update at the same edge that samples `bus_ren`.
- Push latency: an entry pushed at edge N is visible in STATUS and `irq` after edge N. It is readable by a `bus_ren` sampled at edge N+1.
- LED write at edge N:
  - `led_data` updates at N.
  - `led_valid`=1 for exactly the cycle after N.
  - Back-to-back writes produce consecutive pulses, each carrying its own data.

## Structure
- Shared package `gpio_pkg` holds:
  - address constants `GPIO_ADDR_DATA`/`STATUS`/`LED`/`RSVD` (0..3);
  - STATUS bit positions `ST_NOT_EMPTY`=0, `ST_FULL`=1, `ST_OVF`=2, `ST_IRQ_EN`=3, `ST_COUNT_LSB`=4.
- One sub-module, `gpio_evt_fifo`: a synchronous FIFO with push, pop, `count`, full and empty.
  - It drops on full-without-pop and reports a `drop` pulse.
- The top level holds the register decode, `overflow`/`irq_en`, the read-data register and the LED strobe.

## Test plan
- Reset, then 3 pushes (0x11, 0x22, 0x33) -> STATUS count=3, not_empty=1. DATA reads return 0x11, 0x22, 0x33, then 0x00 with count=0.
- 5 pushes with FIFO_DEPTH=4 -> count=4, full=1, overflow=1, and reads return the first 4 values. Writing STATUS=0x04 clears overflow.
- Full FIFO with push 0x55 and DATA read in the same cycle -> read returns the old head, count stays 4, overflow stays 0, and 0x55 is last out.
- LED writes 0xA5 then 0x3C on consecutive cycles -> `led_valid` high for 2 cycles with `led_data` 0xA5 then 0x3C. A LED read returns 0x3C.
- Write STATUS=0x08, then push 0x7E -> `irq`=1 the cycle after the push edge. A DATA read drops `irq` after the pop edge.
- Assert `rstn`=0 asynchronously with count=2 and a LED pulse pending -> all outputs 0 immediately. After release, STATUS=0x00.

Source files
------------

// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO host port: register addresses and STATUS layout.
package gpio_pkg;

  typedef enum logic [1:0] {
    GPIO_ADDR_DATA   = 2'd0,
    GPIO_ADDR_STATUS = 2'd1,
    GPIO_ADDR_LED    = 2'd2,
    GPIO_ADDR_RSVD   = 2'd3
  } gpio_addr_e;

  localparam int unsigned ST_NOT_EMPTY = 0;
  localparam int unsigned ST_FULL      = 1;
  localparam int unsigned ST_OVF       = 2;
  localparam int unsigned ST_IRQ_EN    = 3;
  localparam int unsigned ST_COUNT_LSB = 4;

endpackage

// File: rtl/gpio_evt_fifo.sv
// Event FIFO for captured switch values; pops only when non-empty, drops pushes
// that find it full with no simultaneous pop.
module gpio_evt_fifo #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned W     = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [W-1:0]     din,
  input  logic             pop,
  output logic [W-1:0]     dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             drop
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop_ok, push_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // A pop frees the slot first, so a full FIFO still accepts a same-cycle push.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign drop    = push & full & ~pop_ok;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/gpio_host_port.sv
// CPU-side GPIO endpoint: buffers switch captures, exposes DATA/STATUS/LED
// registers, drives the LED write strobe and a level interrupt.
module gpio_host_port
  import gpio_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DATA_W     = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] gpio_data,
  input  logic              gpio_ready,
  output logic [DATA_W-1:0] led_data,
  output logic              led_valid,
  input  logic [1:0]        bus_addr,
  input  logic              bus_wen,
  input  logic              bus_ren,
  input  logic [DATA_W-1:0] bus_wdata,
  output logic [DATA_W-1:0] bus_rdata,
  output logic              irq
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  gpio_addr_e        addr;
  logic [DATA_W-1:0] fifo_head;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full, fifo_empty, fifo_drop, fifo_pop;
  logic [2:0]        cnt3;
  logic [DATA_W-1:0] status;

  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] led_data_q, led_data_d;
  logic              led_valid_q, led_valid_d;
  logic              ovf_q, ovf_d;
  logic              irq_en_q, irq_en_d;

  assign addr     = gpio_addr_e'(bus_addr);
  assign fifo_pop = bus_ren && (addr == GPIO_ADDR_DATA);

  gpio_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (gpio_ready),
    .din   (gpio_data),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty),
    .drop  (fifo_drop)
  );

  assign cnt3 = 3'(fifo_count);

  always_comb begin
    status                          = '0;
    status[ST_NOT_EMPTY]            = ~fifo_empty;
    status[ST_FULL]                 = fifo_full;
    status[ST_OVF]                  = ovf_q;
    status[ST_IRQ_EN]               = irq_en_q;
    status[ST_COUNT_LSB +: 3]       = cnt3;
  end

  always_comb begin
    rdata_d     = rdata_q;
    led_data_d  = led_data_q;
    led_valid_d = 1'b0;
    ovf_d       = ovf_q;
    irq_en_d    = irq_en_q;

    if (bus_ren) begin
      unique case (addr)
        GPIO_ADDR_DATA:   rdata_d = fifo_empty ? '0 : fifo_head;
        GPIO_ADDR_STATUS: rdata_d = status;
        GPIO_ADDR_LED:    rdata_d = led_data_q;
        default:          rdata_d = '0;
      endcase
    end

    if (bus_wen) begin
      unique case (addr)
        GPIO_ADDR_STATUS: begin
          if (bus_wdata[ST_OVF]) ovf_d = 1'b0;
          irq_en_d = bus_wdata[ST_IRQ_EN];
        end
        GPIO_ADDR_LED: begin
          led_data_d  = bus_wdata;
          led_valid_d = 1'b1;
        end
        default: ;
      endcase
    end

    // A drop in the same cycle as a W1C clear wins, so no overflow goes unreported.
    if (fifo_drop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata_q     <= '0;
      led_data_q  <= '0;
      led_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      irq_en_q    <= 1'b0;
    end else begin
      rdata_q     <= rdata_d;
      led_data_q  <= led_data_d;
      led_valid_q <= led_valid_d;
      ovf_q       <= ovf_d;
      irq_en_q    <= irq_en_d;
    end
  end

  assign bus_rdata = rdata_q;
  assign led_data  = led_data_q;
  assign led_valid = led_valid_q;
  assign irq       = ~fifo_empty & irq_en_q;

endmodule
